bus_timeout_guard: RTL and testbench
====================================

Name: bus_timeout_guard

Overview:
- Watchdog on the CPU memory bus, placed directly downstream of the CPU address decode/mux.
- Monitors every CPU transaction. If the addressed target does not return ready within a programmable number of cycles, the block completes the access itself with an error response.
- Records the faulting address and keeps a fault count.
- Also acts as an MMIO core (own core prefix) for its status and config registers.

Parameters:
- TIMEOUT_CYCLES, 255, reset value of the TIMEOUT register (cycles a transaction may stay pending).
- CNT_WIDTH, 16, width of the pending-cycle counter; TIMEOUT is truncated to this width.

Ports:
- clk  input  1  system clock
- reset_n  input  1  reset, synchronous, active-low
- cpu_valid  input  1  CPU mem_valid
- cpu_instr  input  1  CPU mem_instr
- cpu_addr  input  32  CPU mem_addr
- tgt_ready  input  1  ready selected by the decode mux (pre-register)
- to_ready  output  1  timeout completion strobe; OR'd into the mux ready
- to_rdata  output  32  error read data; valid while to_ready=1
- fault  output  1  sticky fault flag
- guard_trap  output  1  trap request to tk1 force_trap path (see Optional Feature)
- cs  input  1  MMIO chip select
- we  input  1  MMIO write enable
- address  input  8  MMIO word address
- write_data  input  32  MMIO write data
- read_data  output  32  MMIO read data
- ready  output  1  MMIO ready

Behaviour:
- Reset values:
  - to_ready=0, to_rdata=0, fault=0, guard_trap=0, ready=0, read_data=0.
  - counter=0, FAULT_ADDR=0, FAULT_COUNT=0, TIMEOUT=TIMEOUT_CYCLES, state=IDLE.
- FSM states: IDLE, WAIT, RESP, HOLD.
- IDLE:
  - cpu_valid=1 and tgt_ready=0 -> WAIT, counter=1.
  - cpu_valid=1 and tgt_ready=1 -> HOLD.
- WAIT:
  - counter increments each cycle.
  - tgt_ready=1 -> HOLD.
  - Else if counter==TIMEOUT -> RESP.
  - tgt_ready=1 in the same cycle counter==TIMEOUT -> target wins, no fault.
  - cpu_valid dropping -> IDLE, no fault.
- RESP (exactly one cycle):
  - to_ready=1 and to_rdata=32'h0 (illegal instruction: a fetch traps, a data read returns 0).
  - Writes are silently dropped.
  - FAULT_ADDR<=cpu_addr, FAULT_INSTR<=cpu_instr, fault<=1.
  - FAULT_COUNT increments and saturates at 16'hffff.
  - Next state HOLD.
- HOLD:
  - Waits for the one-cycle gap where the mux-ready register is high.
  - Returns to IDLE on the first cycle cpu_valid=0, or after exactly one cycle if cpu_valid stays high (back-to-back transaction).
- Latency: the timeout response is visible to the mux register TIMEOUT+1 cycles after cpu_valid rises.
- TIMEOUT=0 disables the watchdog; the FSM stays in IDLE/HOLD and never enters RESP.
- Self-access: accesses with cs=1 are never timed out, because the MMIO ready is always one cycle.
- MMIO handshake:
  - ready<=cs (one cycle after cs).
  - read_data is registered and valid with ready.
  - Writes take effect on the cs cycle.
- MMIO register map (word address):
  - 0x00 STATUS (R): bit0=fault, bit1=FAULT_INSTR, bit2=guard_trap. Write bit0=1 clears fault, FAULT_INSTR and guard_trap.
  - 0x01 FAULT_ADDR (R).
  - 0x02 FAULT_COUNT (R): 16 bits zero-extended. Any write clears it.
  - 0x03 TIMEOUT (R/W): low CNT_WIDTH bits.
  - Other addresses read 0; writes to them are ignored.
- Simultaneous events:
  - A STATUS clear in the same cycle as RESP: the set wins.
  - A TIMEOUT write while in WAIT takes effect on the next compare.
- Reset mid-transaction: returns to IDLE with all outputs at reset values; no strobe.

Optional Feature:
- Macro BUS_TIMEOUT_TRAP_EN.
- Defined: guard_trap is set in RESP and stays sticky until cleared via STATUS. The top level ORs it into force_trap, so all further CPU accesses return the illegal instruction.
- Undefined: guard_trap is tied to 0 and STATUS bit2 reads 0.

Decomposition:
- Shared package holds:
  - FSM state encodings (2 bits).
  - Register address constants ADDR_STATUS, ADDR_FAULT_ADDR, ADDR_FAULT_COUNT, ADDR_TIMEOUT.
  - ILLEGAL_INSTRUCTION=32'h0.
  - The new MMIO core prefix constant BUS_GUARD_PREFIX=6'h05.
- One sub-module is natural: bus_timeout_counter (loadable, saturating pending-cycle counter with a compare output).

Test Plan:
- Target ready after 3 cycles, TIMEOUT=255 -> no to_ready, fault=0, FAULT_COUNT=0.
- Unresponsive target at 0xC5000000, TIMEOUT=8 -> to_ready pulses on cycle 9 with to_rdata=0; FAULT_ADDR reads 0xC5000000 and FAULT_COUNT reads 1.
- tgt_ready arrives exactly on the cycle counter==TIMEOUT -> no fault, to_ready stays 0.
- Write TIMEOUT=0, then hang the target for 1000 cycles -> no to_ready; STATUS reads 0.
- Two timeouts, then write STATUS=1 -> fault=0 and FAULT_COUNT still reads 2. With BUS_TIMEOUT_TRAP_EN: guard_trap=1 after the first timeout, 0 after the clear.
- Drop reset_n during WAIT at counter=5 -> all outputs return to reset values next cycle and TIMEOUT reads 255.

Source files
------------

// File: rtl/bus_timeout_guard_pkg.sv
// Shared definitions for the CPU bus timeout guard: FSM encoding, MMIO
// register map, the error read value and the core's MMIO address prefix.
// Also provides a saturating 16-bit increment used by the fault counter.
package bus_timeout_guard_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2,
    ST_HOLD = 2'd3
  } guard_state_t;

  localparam logic [7:0] ADDR_STATUS      = 8'h00;
  localparam logic [7:0] ADDR_FAULT_ADDR  = 8'h01;
  localparam logic [7:0] ADDR_FAULT_COUNT = 8'h02;
  localparam logic [7:0] ADDR_TIMEOUT     = 8'h03;

  // Returned on a timed-out access: a fetch decodes as illegal, a load reads 0.
  localparam logic [31:0] ILLEGAL_INSTRUCTION = 32'h0;

  // Upper address bits the decode uses to select this core's MMIO window.
  localparam logic [5:0] BUS_GUARD_PREFIX = 6'h05;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hffff) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Pending-cycle counter for the bus timeout guard.
// Ports: load forces the count to 1, inc advances it (saturating at all-ones),
// hit is high while the count equals limit. Synchronous active-low reset.
module bus_timeout_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic                 inc,
  input  logic [CNT_WIDTH-1:0] limit,
  output logic                 hit
);

  logic [CNT_WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else if (inc && (count != {CNT_WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

  assign hit = (count == limit);

endmodule

// File: rtl/bus_timeout_guard.sv
// Watchdog on the CPU memory bus: completes any access the addressed target
// leaves pending for TIMEOUT cycles with an error response, records the
// faulting address and counts faults. Also an MMIO core for its own registers.
// Ports: cpu_* / tgt_ready observe the bus; to_ready/to_rdata complete a hung
// access; fault/guard_trap are sticky flags; cs/we/address/write_data/
// read_data/ready form the one-cycle MMIO interface.
// Optional: define BUS_TIMEOUT_TRAP_EN to make guard_trap a sticky trap request
// set on every timeout; otherwise guard_trap is tied low and STATUS bit2 reads 0.
module bus_timeout_guard
  import bus_timeout_guard_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_valid,
  input  logic        cpu_instr,
  input  logic [31:0] cpu_addr,
  input  logic        tgt_ready,
  output logic        to_ready,
  output logic [31:0] to_rdata,
  output logic        fault,
  output logic        guard_trap,
  input  logic        cs,
  input  logic        we,
  input  logic [7:0]  address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready
);

  localparam logic [CNT_WIDTH-1:0] TIMEOUT_RST = CNT_WIDTH'(TIMEOUT_CYCLES);

  guard_state_t         state, state_next;
  logic                 cnt_load, cnt_inc, cnt_hit;
  logic [CNT_WIDTH-1:0] timeout;
  logic [31:0]          fault_addr;
  logic                 fault_instr;
  logic [15:0]          fault_count;
  logic [15:0]          fcnt_base;
  logic [31:0]          rd_mux;
  logic                 resp;
  logic                 mmio_wr, status_clr, fcnt_clr, timeout_wr;
  logic                 unused_wdata;

  assign resp       = (state == ST_RESP);
  assign mmio_wr    = cs && we;
  assign status_clr = mmio_wr && (address == ADDR_STATUS) && write_data[0];
  assign fcnt_clr   = mmio_wr && (address == ADDR_FAULT_COUNT);
  assign timeout_wr = mmio_wr && (address == ADDR_TIMEOUT);
  assign unused_wdata = ^write_data;

  bus_timeout_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (cnt_load),
    .inc     (cnt_inc),
    .limit   (timeout),
    .hit     (cnt_hit)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_load   = 1'b0;
    cnt_inc    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cpu_valid) begin
          if (tgt_ready) begin
            state_next = ST_HOLD;
          end else if (timeout != '0) begin
            // TIMEOUT=0 leaves a hung access unwatched.
            state_next = ST_WAIT;
            cnt_load   = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (!cpu_valid) begin
          state_next = ST_IDLE;
        end else if (tgt_ready) begin
          // Target wins even when the compare hits this same cycle.
          state_next = ST_HOLD;
        end else if (cnt_hit) begin
          state_next = ST_RESP;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_RESP: state_next = ST_HOLD;
      // One-cycle gap while the mux ready register presents the completion.
      ST_HOLD: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign to_ready = resp;
  assign to_rdata = ILLEGAL_INSTRUCTION;

  // A fault count clear and a timeout in the same cycle leave a count of 1.
  assign fcnt_base = fcnt_clr ? 16'h0 : fault_count;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fault       <= 1'b0;
      fault_instr <= 1'b0;
      fault_addr  <= 32'h0;
      fault_count <= 16'h0;
      timeout     <= TIMEOUT_RST;
    end else begin
      // Set has priority over a STATUS clear in the same cycle.
      if (resp) begin
        fault       <= 1'b1;
        fault_instr <= cpu_instr;
        fault_addr  <= cpu_addr;
      end else if (status_clr) begin
        fault       <= 1'b0;
        fault_instr <= 1'b0;
      end
      fault_count <= resp ? sat_inc16(fcnt_base) : fcnt_base;
      if (timeout_wr) begin
        timeout <= write_data[CNT_WIDTH-1:0];
      end
    end
  end

`ifdef BUS_TIMEOUT_TRAP_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      guard_trap <= 1'b0;
    end else if (resp) begin
      guard_trap <= 1'b1;
    end else if (status_clr) begin
      guard_trap <= 1'b0;
    end
  end
`else
  assign guard_trap = 1'b0;
`endif

  always_comb begin
    rd_mux = 32'h0;
    case (address)
      ADDR_STATUS:      rd_mux = {29'h0, guard_trap, fault_instr, fault};
      ADDR_FAULT_ADDR:  rd_mux = fault_addr;
      ADDR_FAULT_COUNT: rd_mux = {16'h0, fault_count};
      ADDR_TIMEOUT:     rd_mux = 32'(timeout);
      default:          rd_mux = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ready     <= 1'b0;
      read_data <= 32'h0;
    end else begin
      ready     <= cs;
      read_data <= (cs && !we) ? rd_mux : 32'h0;
    end
  end

endmodule

// File: tb/tb_bus_timeout_guard.sv
// Bench for bus_timeout_guard: directed bus/MMIO sequences, a transaction-age
// model checked against the DUT every cycle, and literal expectations that
// pin the model (strobe delay, fault address/count, reset values).
module tb_bus_timeout_guard;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_valid, cpu_instr, tgt_ready;
  logic [31:0] cpu_addr;
  logic        to_ready, fault, guard_trap, ready;
  logic [31:0] to_rdata, read_data;
  logic        cs, we;
  logic [7:0]  address;
  logic [31:0] write_data;

  always #5 clk = ~clk;

  bus_timeout_guard dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cpu_valid  (cpu_valid),
    .cpu_instr  (cpu_instr),
    .cpu_addr   (cpu_addr),
    .tgt_ready  (tgt_ready),
    .to_ready   (to_ready),
    .to_rdata   (to_rdata),
    .fault      (fault),
    .guard_trap (guard_trap),
    .cs         (cs),
    .we         (we),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int strobe_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model state: register contents plus the age of the pending access.
  int          m_timeout, m_fcount, m_age, old_to;
  bit          m_fault, m_instr, m_trap, m_strobe, m_gap, m_ready, m_rd_vld;
  logic [31:0] m_faddr, m_rdata, rd_tmp;

  function automatic logic [31:0] m_reg(input logic [7:0] a);
    case (a)
      8'h00:   return {29'h0, m_trap, m_instr, m_fault};
      8'h01:   return m_faddr;
      8'h02:   return 32'(m_fcount);
      8'h03:   return 32'(m_timeout);
      default: return 32'h0;
    endcase
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
    if (!reset_n) begin
      m_timeout = 255; m_fcount = 0; m_age = 0; m_faddr = 32'h0;
      m_fault = 0; m_instr = 0; m_trap = 0; m_strobe = 0; m_gap = 0;
      m_ready = 0; m_rd_vld = 0; m_rdata = 32'h0;
    end else begin
      rd_tmp   = m_reg(address);
      m_ready  = cs;
      m_rd_vld = cs && !we;
      m_rdata  = m_rd_vld ? rd_tmp : 32'h0;
      old_to   = m_timeout;
      if (cs && we) begin
        case (address)
          8'h00: if (write_data[0]) begin m_fault = 0; m_instr = 0; m_trap = 0; end
          8'h02: m_fcount = 0;
          8'h03: m_timeout = int'(write_data[15:0]);
          default: ;
        endcase
      end
      // An access waits cycles 1..T+1 unanswered; the next cycle is the strobe.
      if (m_strobe) begin
        m_fault = 1; m_instr = cpu_instr; m_faddr = cpu_addr;
`ifdef BUS_TIMEOUT_TRAP_EN
        m_trap = 1;
`endif
        if (m_fcount < 65535) m_fcount++;
        m_strobe = 0; m_gap = 1; m_age = 0;
      end else if (m_gap) begin
        m_gap = 0;
      end else if (!cpu_valid) begin
        m_age = 0;
      end else if (tgt_ready) begin
        m_age = 0; m_gap = 1;
      end else if (m_age > 0 || old_to != 0) begin
        m_age++;
        if (old_to != 0 && m_age == old_to + 1) m_strobe = 1;
      end
    end
    #1;
    if (to_ready === 1'b1) strobe_cnt++;
    check("to_ready", 32'(to_ready), 32'(m_strobe));
    if (m_strobe) check("to_rdata", to_rdata, 32'h0);
    check("fault", 32'(fault), 32'(m_fault));
    check("guard_trap", 32'(guard_trap), 32'(m_trap));
    check("ready", 32'(ready), 32'(m_ready));
    if (m_rd_vld) check("read_data", read_data, m_rdata);
  end

  // Tasks start and end just after a falling edge.
  task automatic mmio_read(input logic [7:0] a, output logic [31:0] d);
    cs = 1'b1; we = 1'b0; address = a;
    @(negedge clk);
    d = read_data;
    cs = 1'b0;
  endtask

  task automatic mmio_write(input logic [7:0] a, input logic [31:0] d);
    cs = 1'b1; we = 1'b1; address = a; write_data = d;
    @(negedge clk);
    cs = 1'b0; we = 1'b0;
  endtask

  // Hold an access against a silent target until the strobe (bounded).
  task automatic hang(input logic [31:0] a, input logic instr, output int delay);
    int t0;
    bit got;
    cpu_valid = 1'b1; cpu_addr = a; cpu_instr = instr; tgt_ready = 1'b0;
    t0 = cyc; got = 0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      if (to_ready === 1'b1) got = 1;
    end
    delay = got ? (cyc - t0) : -1;
    @(negedge clk);
    cpu_valid = 1'b0;
    @(negedge clk);
  endtask

  logic [31:0] d;
  int          dl, s0;

  initial begin
    reset_n = 1'b0; cpu_valid = 1'b0; cpu_instr = 1'b0; cpu_addr = 32'h0;
    tgt_ready = 1'b0; cs = 1'b0; we = 1'b0; address = 8'h0; write_data = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_to_ready", 32'(to_ready), 32'h0);
    check("rst_fault", 32'(fault), 32'h0);
    check("rst_ready", 32'(ready), 32'h0);
    check("rst_read_data", read_data, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    mmio_read(8'h03, d); check("rst_timeout", d, 32'd255);

    // Target answers on its 4th cycle with the default TIMEOUT.
    cpu_valid = 1'b1; cpu_addr = 32'h2000_0010; cpu_instr = 1'b1;
    repeat (3) @(negedge clk);
    tgt_ready = 1'b1;
    @(negedge clk);
    tgt_ready = 1'b0; cpu_valid = 1'b0;
    @(negedge clk);
    check("ok_fault", 32'(fault), 32'h0);
    mmio_read(8'h02, d); check("ok_fcount", d, 32'h0);

    // Silent target, TIMEOUT=8: strobe on cycle 9.
    mmio_write(8'h03, 32'd8);
    hang(32'hC500_0000, 1'b0, dl);
    check("hang1_delay", 32'(dl), 32'd9);
`ifdef BUS_TIMEOUT_TRAP_EN
    check("hang1_trap", 32'(guard_trap), 32'h1);
`endif
    mmio_read(8'h01, d); check("hang1_faddr", d, 32'hC500_0000);
    mmio_read(8'h02, d); check("hang1_fcount", d, 32'h1);

    // Target ready on the very cycle the count reaches TIMEOUT.
    s0 = strobe_cnt;
    cpu_valid = 1'b1; cpu_addr = 32'h4000_0000; cpu_instr = 1'b0;
    repeat (8) @(negedge clk);
    tgt_ready = 1'b1;
    @(negedge clk);
    tgt_ready = 1'b0; cpu_valid = 1'b0;
    @(negedge clk);
    check("race_strobes", 32'(strobe_cnt - s0), 32'h0);
    mmio_read(8'h02, d); check("race_fcount", d, 32'h1);

    // Second timeout on a fetch, then clear STATUS.
    hang(32'h3000_0004, 1'b1, dl);
    check("hang2_delay", 32'(dl), 32'd9);
    mmio_read(8'h02, d); check("hang2_fcount", d, 32'h2);
    mmio_read(8'h00, d);
`ifdef BUS_TIMEOUT_TRAP_EN
    check("hang2_status", d, 32'h7);
`else
    check("hang2_status", d, 32'h3);
`endif
    mmio_write(8'h00, 32'h1);
    check("clr_fault", 32'(fault), 32'h0);
    check("clr_trap", 32'(guard_trap), 32'h0);
    mmio_read(8'h02, d); check("clr_fcount", d, 32'h2);

    // TIMEOUT=0 disables the watchdog.
    mmio_write(8'h03, 32'h0);
    s0 = strobe_cnt;
    cpu_valid = 1'b1; cpu_addr = 32'h5000_0000;
    repeat (1000) @(negedge clk);
    cpu_valid = 1'b0;
    @(negedge clk);
    check("dis_strobes", 32'(strobe_cnt - s0), 32'h0);
    mmio_read(8'h00, d); check("dis_status", d, 32'h0);

    // Short timeout to set fault, then reset in the middle of a wait.
    mmio_write(8'h03, 32'd3);
    hang(32'h6000_0000, 1'b0, dl);
    check("hang3_delay", 32'(dl), 32'd4);
    mmio_write(8'h03, 32'd20);
    mmio_read(8'h01, d);
    cpu_valid = 1'b1; cpu_addr = 32'h7000_0000;
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("mid_to_ready", 32'(to_ready), 32'h0);
    check("mid_fault", 32'(fault), 32'h0);
    check("mid_trap", 32'(guard_trap), 32'h0);
    check("mid_read_data", read_data, 32'h0);
    cpu_valid = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    mmio_read(8'h03, d); check("mid_timeout", d, 32'd255);
    mmio_read(8'h02, d); check("mid_fcount", d, 32'h0);
    mmio_read(8'h01, d); check("mid_faddr", d, 32'h0);
    mmio_read(8'h07, d); check("unmapped", d, 32'h0);
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
